// File: rtl/add512_pkg.sv
// ---------------------------------------------------------------------------
// add512_pkg
// Shared constants and types for the sequential 512-bit adder.
//   WIDTH  : total operand width (multiple of SLICE)
//   SLICE  : width of the shared slice adder
//   NSLICE : number of slices walked per operation (derived)
//   IDX_W  : width of the slice index counter
//   seq_state_t : controller states IDLE / RUN / DONE
// Optional feature macro used by the controller: ADD512_SUB_EN.
// ---------------------------------------------------------------------------
package add512_pkg;

  localparam int WIDTH  = 512;
  localparam int SLICE  = 32;
  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = $clog2(NSLICE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/add_slice32.sv
// ---------------------------------------------------------------------------
// add_slice32
// Combinational 32-bit adder with carry in/out, built from two 16-bit
// lookahead groups: cin feeds the low group, the low group's carry feeds
// the high group.
// Ports:
//   a, b  in  32  addends
//   cin   in  1   carry in
//   sum   out 32  a + b + cin (low 32 bits)
//   cout  out 1   carry out of bit 31
// ---------------------------------------------------------------------------
module add_slice32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  // Returns {carry_out, sum[15:0]} for one 16-bit group using per-bit
  // generate/propagate terms; the unrolled carry expressions collapse into
  // lookahead logic.
  function automatic logic [16:0] cla16(input logic [15:0] x,
                                        input logic [15:0] y,
                                        input logic        ci);
    logic [15:0] g;
    logic [15:0] p;
    logic [16:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    for (int i = 0; i < 16; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    return {c[16], p ^ c[15:0]};
  endfunction

  logic [16:0] lo_grp;
  logic [16:0] hi_grp;

  assign lo_grp = cla16(a[15:0],  b[15:0],  cin);
  assign hi_grp = cla16(a[31:16], b[31:16], lo_grp[16]);

  assign sum  = {hi_grp[15:0], lo_grp[15:0]};
  assign cout = hi_grp[16];

endmodule

// File: rtl/add512_seq_ctrl.sv
// ---------------------------------------------------------------------------
// add512_seq_ctrl
// Adds two WIDTH-bit operands by walking one shared 32-bit slice adder over
// NSLICE cycles, least-significant slice first, with the carry chained
// through a register. valid/ready handshake on both sides.
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      operands valid
//   in_ready   out  1      controller can accept operands (IDLE)
//   a, b       in   WIDTH  operands
//   sub        in   1      subtract request (only with ADD512_SUB_EN)
//   out_valid  out  1      sum/cout valid (DONE)
//   out_ready  in   1      consumer accepts the result
//   sum        out  WIDTH  result, modulo 2^WIDTH
//   cout       out  1      carry out of bit WIDTH-1 (1 = no borrow when
//                          subtracting)
//   busy       out  1      high in RUN or DONE
// Optional feature macro: ADD512_SUB_EN (adds the sub port; a-b is formed
// as a + ~b + 1).
// ---------------------------------------------------------------------------
module add512_seq_ctrl
  import add512_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ADD512_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;

  logic [SLICE-1:0] s_a, s_b, s_sum;
  logic             s_cout;

  assign s_a = a_q[idx_q*SLICE +: SLICE];
  assign s_b = b_q[idx_q*SLICE +: SLICE];

  add_slice32 u_slice (
    .a    (s_a),
    .b    (s_b),
    .cin  (carry_q),
    .sum  (s_sum),
    .cout (s_cout)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = RUN;
`ifdef ADD512_SUB_EN
          // Two's-complement subtract: invert b and seed the carry with 1.
          if (sub) begin
            b_d     = ~b;
            carry_d = 1'b1;
          end
`endif
        end
      end
      RUN: begin
        sum_d[idx_q*SLICE +: SLICE] = s_sum;
        carry_d = s_cout;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IDX_W'(NSLICE - 1)) begin
          cout_d  = s_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      sum_q   <= '0;
      // NOTE: the wide operand registers are cleared too, so an aborted
      // operation leaves no stale operand data behind.
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_add512_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_add512_seq_ctrl
// Directed self-checking bench for add512_seq_ctrl. Expected values are
// hand-computed constants. Subtract vectors are exercised when the bench is
// built with ADD512_SUB_EN.
// ---------------------------------------------------------------------------
module tb_add512_seq_ctrl;
  import add512_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef ADD512_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  int errors = 0;
  int checks = 0;

  add512_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef ADD512_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample/drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one cycle from IDLE; returns in cycle 1 (first RUN).
  task automatic start(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    check("in_ready_before_start", WIDTH'(in_ready), WIDTH'(1));
    a        = av;
    b        = bv;
`ifdef ADD512_SUB_EN
    sub      = 1'b0;
`endif
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

`ifdef ADD512_SUB_EN
  task automatic start_sub(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    check("in_ready_before_sub", WIDTH'(in_ready), WIDTH'(1));
    a        = av;
    b        = bv;
    sub      = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    sub      = 1'b0;
  endtask
`endif

  // Bounded wait for out_valid; an expired budget is a failed comparison.
  task automatic wait_valid(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check({tag, "_out_valid_timeout"}, WIDTH'(out_valid), WIDTH'(1));
  endtask

  // Collect the result with out_ready already 1, then confirm the return to IDLE.
  task automatic finish_op(input string tag, input logic [WIDTH-1:0] exp_sum,
                           input logic exp_cout);
    wait_valid(tag);
    check({tag, "_sum"},  sum,          exp_sum);
    check({tag, "_cout"}, WIDTH'(cout), WIDTH'(exp_cout));
    step();
    check({tag, "_out_valid_drop"}, WIDTH'(out_valid), WIDTH'(0));
    check({tag, "_in_ready_back"},  WIDTH'(in_ready),  WIDTH'(1));
  endtask

  initial begin
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] msb;
    logic [WIDTH-1:0] pat_a;
    logic [WIDTH-1:0] pat_b;
    logic [WIDTH-1:0] pat_sum;
    logic [WIDTH-1:0] bp_a;
    logic [WIDTH-1:0] bp_b;
    logic [WIDTH-1:0] bp_sum;
    int               seen_valid;

    ones    = '1;
    msb     = '0;
    msb[WIDTH-1] = 1'b1;
    pat_a   = '0;
    pat_b   = '0;
    pat_sum = '0;
    for (int i = 0; i < NSLICE; i++) begin
      pat_a[i*SLICE +: SLICE] = 32'h1234_5678;
      pat_b[i*SLICE +: SLICE] = 32'hEDCB_A988;
      if (i > 0) pat_sum[i*SLICE +: SLICE] = 32'h0000_0001;
    end
    // Carry out of slice 0 into slice 1, no final carry.
    bp_a   = '0;
    bp_a[32:0] = 33'h1_FFFF_FFFF;
    bp_b   = WIDTH'(1);
    bp_sum = '0;
    bp_sum[33:0] = 34'h2_0000_0000;

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
`ifdef ADD512_SUB_EN
    sub       = 1'b0;
`endif
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state.
    check("rst_in_ready",  WIDTH'(in_ready),  WIDTH'(1));
    check("rst_out_valid", WIDTH'(out_valid), WIDTH'(0));
    check("rst_busy",      WIDTH'(busy),      WIDTH'(0));
    check("rst_sum",       sum,               '0);
    check("rst_cout",      WIDTH'(cout),      WIDTH'(0));

    // Latency: 0 + 0, in_ready low in cycles 1..17, out_valid in cycle 17.
    start('0, '0);
    for (int c = 1; c <= 16; c++) begin
      check($sformatf("lat_in_ready_c%0d", c),  WIDTH'(in_ready),  WIDTH'(0));
      check($sformatf("lat_out_valid_c%0d", c), WIDTH'(out_valid), WIDTH'(0));
      check($sformatf("lat_busy_c%0d", c),      WIDTH'(busy),      WIDTH'(1));
      step();
    end
    check("lat_out_valid_c17", WIDTH'(out_valid), WIDTH'(1));
    check("lat_in_ready_c17",  WIDTH'(in_ready),  WIDTH'(0));
    check("lat_sum",           sum,               '0);
    check("lat_cout",          WIDTH'(cout),      WIDTH'(0));
    step();
    check("lat_in_ready_c18",  WIDTH'(in_ready),  WIDTH'(1));
    check("lat_out_valid_c18", WIDTH'(out_valid), WIDTH'(0));

    // All ones + 1: carry ripples through every slice.
    start(ones, WIDTH'(1));
    finish_op("ones_plus_one", '0, 1'b1);

    // 2^511 + 2^511.
    start(msb, msb);
    finish_op("msb_plus_msb", '0, 1'b1);

    // Backpressure: hold out_ready low for 5 cycles with in_valid asserted.
    out_ready = 1'b0;
    start(bp_a, bp_b);
    wait_valid("bp");
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      a        = ones;
      b        = ones;
      check($sformatf("bp_out_valid_%0d", k), WIDTH'(out_valid), WIDTH'(1));
      check($sformatf("bp_in_ready_%0d", k),  WIDTH'(in_ready),  WIDTH'(0));
      check($sformatf("bp_sum_%0d", k),       sum,               bp_sum);
      check($sformatf("bp_cout_%0d", k),      WIDTH'(cout),      WIDTH'(0));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_beat_valid", WIDTH'(out_valid), WIDTH'(1));
    check("bp_beat_sum",   sum,               bp_sum);
    step();
    check("bp_after_out_valid", WIDTH'(out_valid), WIDTH'(0));
    check("bp_after_in_ready",  WIDTH'(in_ready),  WIDTH'(1));
    check("bp_after_busy",      WIDTH'(busy),      WIDTH'(0));
    step();
    check("bp_single_beat",     WIDTH'(out_valid), WIDTH'(0));

    // Per-slice pattern summing to 2^32, carry chains through all slices.
    start(pat_a, pat_b);
    finish_op("pattern", pat_sum, 1'b1);

    // Reset in RUN cycle 7.
    start(ones, WIDTH'(1));
    for (int c = 1; c < 7; c++) step();
    check("mid_busy_c7", WIDTH'(busy), WIDTH'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_in_ready",  WIDTH'(in_ready),  WIDTH'(1));
    check("mid_out_valid", WIDTH'(out_valid), WIDTH'(0));
    check("mid_busy",      WIDTH'(busy),      WIDTH'(0));
    check("mid_sum",       sum,               '0);
    check("mid_cout",      WIDTH'(cout),      WIDTH'(0));
    seen_valid = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid !== 1'b0) seen_valid++;
      step();
    end
    check("mid_no_beat", WIDTH'(seen_valid), WIDTH'(0));

    // Fresh operation after the abort.
    start(pat_a, pat_b);
    finish_op("after_reset", pat_sum, 1'b1);

`ifdef ADD512_SUB_EN
    // 5 - 7 = 2^512 - 2, borrow (cout = 0).
    start_sub(WIDTH'(5), WIDTH'(7));
    finish_op("sub_5_7", ones ^ WIDTH'(1), 1'b0);
    // 7 - 5 = 2, no borrow (cout = 1).
    start_sub(WIDTH'(7), WIDTH'(5));
    finish_op("sub_7_5", WIDTH'(2), 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
